mul_pipe: RTL
=============

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width in bits; legal values are even and 8..64.
REQ-002 Parameter STAGES, default 4, sets the accept-to-result latency in cycles; legal range is 2..6.
REQ-003 Parameter TAG_W, default 6, sets the width of the opaque tag carried alongside each operation.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous kill of every in-flight operation.
REQ-007 in_valid  input  1  operands and op are presented this cycle.
REQ-008 in_ready  output  1  the unit can accept an operation this cycle.
REQ-009 in_a, in_b  input  WIDTH each  multiplicand and multiplier.
REQ-010 in_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-011 in_tag  input  TAG_W  tag returned unchanged with the result.
REQ-012 out_valid  output  1  out_result and out_tag hold a completed operation.
REQ-013 out_ready  input  1  the consumer takes the result this cycle.
REQ-014 out_result  output  WIDTH  selected half of the product.
REQ-015 out_tag  output  TAG_W  tag of the operation in out_result.

Function
REQ-016 Each pipeline stage SHALL hold a valid bit, a tag, an op, and partial-product or compressor state.
REQ-017 The pipeline SHALL advance as a whole when adv = ~out_valid | out_ready; otherwise every stage SHALL hold its contents.
REQ-018 in_ready SHALL equal adv & ~flush & ~rst, computed combinationally.
REQ-019 An operation SHALL be accepted when in_valid & in_ready.
REQ-020 An accepted operation SHALL appear with out_valid=1 exactly STAGES cycles after acceptance, provided adv stays high throughout.
REQ-021 Throughput SHALL be one operation per cycle with no bubbles while out_ready=1.
REQ-022 out_result, out_tag and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Operand extension to WIDTH+1 bits: in_a SHALL be sign-extended for MULH and MULHSU and zero-extended otherwise; in_b SHALL be sign-extended for MULH and zero-extended otherwise.
REQ-024 The signed (WIDTH+1)x(WIDTH+1) product SHALL be reduced with a Dadda/Wallace compressor tree partitioned across stages 1..STAGES-1, with the final carry-propagate add in the last stage.
REQ-025 Result selection: MUL SHALL return product[WIDTH-1:0]; MULH, MULHSU and MULHU SHALL return product[2*WIDTH-1:WIDTH].
REQ-026 No overflow, exception or saturation SHALL exist; results wrap modulo 2^WIDTH per the RV32M definitions.
REQ-027 When flush=1, every stage valid bit and out_valid SHALL be 0 on the next cycle.
REQ-028 An operation presented in a flush cycle SHALL be dropped.
REQ-029 flush SHALL take priority over adv and over acceptance.
REQ-030 When flush=1 and out_ready=1 in the same cycle, the consumer SHALL see the current result as taken; nothing new is produced.
REQ-031 Tags SHALL exit in acceptance order; no reordering and no duplication.
REQ-032 Data registers of internal stages SHALL need no reset; only valid bits and the output stage are reset.

Reset
REQ-033 While rst=1, in_ready SHALL be 0.
REQ-034 On the cycle after rst=1, out_valid, all stage valid bits, out_result and out_tag SHALL be 0.
REQ-035 rst asserted mid-operation SHALL discard all in-flight operations; no result from before rst SHALL ever appear after it.
REQ-036 rst SHALL take priority over flush and over in_valid.

Verification
REQ-037 Latency (WIDTH=32, STAGES=4, out_ready=1): MULHU 0xFFFFFFFF x 0xFFFFFFFF with tag 5, accepted at cycle t -> out_valid at t+4 with out_result 0xFFFFFFFE, out_tag 5.
REQ-038 Signed corners: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL 0xFFFFFFFF x 0x00000003 -> 0xFFFFFFFD.
REQ-039 Streaming with backpressure: 20 back-to-back random ops, out_ready toggled pseudo-randomly -> results in order, each equal to the reference model, held stable while out_ready=0, none lost or duplicated.
REQ-040 Flush: 3 ops in flight, flush=1 with in_valid=1 -> out_valid=0 next cycle and the 4 ops never emerge; an op accepted the cycle after flush emerges STAGES cycles later.
REQ-041 Reset mid-stream: rst for 1 cycle with 2 ops in flight -> no stale results; an op accepted right after reset completes normally.
REQ-042 Parameter sweep: WIDTH=8 with STAGES=2 and WIDTH=64 with STAGES=6, exhaustive (8-bit) or random (64-bit) ops -> all results match the reference model.

Source files
------------

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined RV32M-style multiplier (MUL/MULH/MULHSU/MULHU).
// Partial products are reduced by 3:2 carry-save levels spread over stages
// 1..STAGES-1; the last stage does the carry-propagate add and selects the
// result half. The whole pipe stalls together on output backpressure.
module mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    // Only the low 2*WIDTH product bits are ever selected, so all rows are
    // kept modulo 2^(2*WIDTH).
    localparam int PW = 2 * WIDTH;
    // WIDTH rows for b[WIDTH-1:0], plus two for the negative-weight sign bit
    // of the extended multiplier (~a << WIDTH and +1 << WIDTH).
    localparam int NR = WIDTH + 2;
    localparam int NP = ((NR + 2) / 3) * 3;
    localparam int NS = STAGES - 1;
    localparam logic [PW-1:0] PP_ONE = {{(PW - 1){1'b0}}, 1'b1};

    function automatic int count_levels(input int rows);
        int r;
        int l;
        r = rows;
        l = 0;
        while (r > 2) begin
            r = r - r / 3;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = count_levels(NR);
    localparam int LPS    = (LEVELS + NS - 1) / NS;

    typedef logic [NP-1:0][PW-1:0] rows_t;

    // One 3:2 level; live rows stay packed at the low indices.
    function automatic rows_t csa_level(input rows_t r);
        rows_t o;
        o = '0;
        for (int g = 0; g < NP / 3; g++) begin
            o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
            o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                        (r[3*g+1] & r[3*g+2])) << 1;
        end
        return o;
    endfunction

    logic                 adv;
    rows_t                pp;
    rows_t                comp_out [1:NS];
    logic [NS:1]          st_valid;
    logic [TAG_W-1:0]     st_tag   [1:NS];
    logic [1:0]           st_op    [1:NS];
    rows_t                st_rows  [1:NS];
    logic [PW-1:0]        sum;
    logic [WIDTH-1:0]     result;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~flush & ~rst;

    // Operand extension and partial-product rows
    always_comb begin
        logic          a_sx;
        logic          b_top;
        logic [PW-1:0] a_full;
        a_sx   = (in_op == 2'b01 || in_op == 2'b10) & in_a[WIDTH-1];
        b_top  = (in_op == 2'b01) & in_b[WIDTH-1];
        a_full = {{WIDTH{a_sx}}, in_a};
        pp     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_b[i]) pp[i] = a_full << i;
        end
        if (b_top) begin
            pp[WIDTH]   = (~a_full) << WIDTH;
            pp[WIDTH+1] = PP_ONE << WIDTH;
        end
    end

    // Compressor slice feeding each intermediate stage register
    always_comb begin
        comp_out[1] = pp;
        for (int k = 2; k <= NS; k++) comp_out[k] = st_rows[k-1];
        for (int k = 1; k <= NS; k++) begin
            for (int l = 0; l < LPS; l++) comp_out[k] = csa_level(comp_out[k]);
        end
    end

    // Final carry-propagate add and half selection
    always_comb begin
        sum    = st_rows[NS][0] + st_rows[NS][1];
        result = (st_op[NS] == 2'b00) ? sum[WIDTH-1:0] : sum[PW-1:WIDTH];
    end

    // Stage payloads move with the pipe; they need no reset
    always_ff @(posedge clk) begin
        if (adv) begin
            st_tag[1]  <= in_tag;
            st_op[1]   <= in_op;
            st_rows[1] <= comp_out[1];
            for (int k = 2; k <= NS; k++) begin
                st_tag[k]  <= st_tag[k-1];
                st_op[k]   <= st_op[k-1];
                st_rows[k] <= comp_out[k];
            end
        end
    end

    // Valid bits and output register; reset beats flush, flush beats advance
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid   <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            st_valid  <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            st_valid[1] <= in_valid & in_ready;
            for (int k = 2; k <= NS; k++) st_valid[k] <= st_valid[k-1];
            out_valid  <= st_valid[NS];
            out_result <= result;
            out_tag    <= st_tag[NS];
        end
    end

endmodule
